// File: rtl/bias_act_unit.sv
`default_nettype none
// ============================================================================
//  Module   : bias_act_unit
//  Purpose  : Per-channel bias add with saturation followed by an activation
//             (ReLU / leaky ReLU / pass-through) over a W x H x D feature map
//             held in DRAM. Parameters and biases are fetched from DRAM first,
//             then every pixel is read, transformed and written back.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             enable            - start request, sampled in IDLE only
//             dram_valid/data_in- read data handshake from DRAM
//             addr_in/dram_en_rd- read address / read request
//             addr_out/data_out/dram_en_wr - registered write port
//             busy/done/err     - status (done/err are one-cycle pulses)
//  Config   : define BIAS_ACT_LEAKY_EN to enable leaky mode (mode 1) and its
//             4-bit arithmetic-shift logic; otherwise mode 1 acts as ReLU.
//  Revision : 1.0 - initial release
// ============================================================================
module bias_act_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int KNL_MAXNUM = 64,
    parameter int DIM_WIDTH  = 6,
    parameter int PARAM_BASE = 0,
    parameter int BIAS_BASE  = 61440,
    parameter int FMAP_BASE  = 131072,
    parameter int OUT_BASE   = 131072
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic                  dram_en_rd,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  dram_en_wr,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int IDXW = (KNL_MAXNUM > 1) ? $clog2(KNL_MAXNUM) : 1;
    localparam logic [DIM_WIDTH-1:0]  c_DIM_ONE  = DIM_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] c_SAT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] c_SAT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LD_PARAM = 3'd1,
        S_CHECK    = 3'd2,
        S_LD_BIAS  = 3'd3,
        S_EVAL     = 3'd4,
        S_FLUSH    = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DIM_WIDTH-1:0]  r_W, r_H, r_D;
    logic [DIM_WIDTH-1:0]  r_c;              // bias load index
    logic [DIM_WIDTH-1:0]  r_w, r_h, r_d;    // pixel coordinates
    logic [1:0]            r_mode;
    logic [1:0]            r_idx;            // parameter word index
`ifdef BIAS_ACT_LEAKY_EN
    logic [3:0]            r_shift;
`endif
    logic [ADDR_WIDTH-1:0] r_ptr;            // linear pixel offset p
    logic [ADDR_WIDTH-1:0] r_addr_in;
    logic [ADDR_WIDTH-1:0] r_addr_out;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_wr;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_bias [KNL_MAXNUM];

    logic                  w_dim_bad;
    logic                  w_c_last;
    logic                  w_w_last, w_h_last, w_d_last, w_px_last;
    logic [DATA_WIDTH-1:0] w_bias_sel;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_sat;
    logic [DATA_WIDTH-1:0] w_act;

    // ------------------------------------------------------------------
    // Dimension checks and counter terminal conditions
    // ------------------------------------------------------------------
    assign w_dim_bad = (r_W == '0) || (r_H == '0) || (r_D == '0) ||
                       (32'(r_D) > 32'(KNL_MAXNUM));
    assign w_c_last  = (r_c == (r_D - c_DIM_ONE));
    assign w_w_last  = (r_w == (r_W - c_DIM_ONE));
    assign w_h_last  = (r_h == (r_H - c_DIM_ONE));
    assign w_d_last  = (r_d == (r_D - c_DIM_ONE));
    assign w_px_last = w_w_last && w_h_last && w_d_last;

    // r_d < D <= KNL_MAXNUM is guaranteed once CHECK has passed
    assign w_bias_sel = r_bias[IDXW'(r_d)];

    // ------------------------------------------------------------------
    // Saturating add: one guard bit; overflow when the two top bits differ
    // ------------------------------------------------------------------
    assign w_sum = {data_in[DATA_WIDTH-1], data_in} +
                   {w_bias_sel[DATA_WIDTH-1], w_bias_sel};

    always_comb begin
        w_sat = w_sum[DATA_WIDTH-1:0];
        if (w_sum[DATA_WIDTH] != w_sum[DATA_WIDTH-1]) begin
            w_sat = w_sum[DATA_WIDTH] ? c_SAT_MIN : c_SAT_MAX;
        end
    end

    // ------------------------------------------------------------------
    // Activation
    // ------------------------------------------------------------------
    always_comb begin
        w_act = w_sat;
        case (r_mode)
            2'd2: w_act = w_sat;
`ifdef BIAS_ACT_LEAKY_EN
            2'd1: begin
                if (w_sat[DATA_WIDTH-1]) begin
                    w_act = DATA_WIDTH'($signed(w_sat) >>> r_shift);
                end
            end
`endif
            default: begin
                if (w_sat[DATA_WIDTH-1]) begin
                    w_act = '0;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        dram_en_rd = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (enable) w_next = S_LD_PARAM;
            end
            S_LD_PARAM: begin
                dram_en_rd = 1'b1;
                if (dram_valid && (r_idx == 2'd3)) w_next = S_CHECK;
            end
            S_CHECK: begin
                w_next = w_dim_bad ? S_DONE : S_LD_BIAS;
            end
            S_LD_BIAS: begin
                dram_en_rd = 1'b1;
                if (dram_valid && w_c_last) w_next = S_EVAL;
            end
            S_EVAL: begin
                dram_en_rd = 1'b1;
                if (dram_valid && w_px_last) w_next = S_FLUSH;
            end
            S_FLUSH: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                err    = r_err;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, counters and address generation
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_W        <= '0;
            r_H        <= '0;
            r_D        <= '0;
            r_c        <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_d        <= '0;
            r_mode     <= '0;
            r_idx      <= '0;
`ifdef BIAS_ACT_LEAKY_EN
            r_shift    <= '0;
`endif
            r_ptr      <= '0;
            r_addr_in  <= '0;
            r_addr_out <= '0;
            r_data_out <= '0;
            r_wr       <= 1'b0;
            r_err      <= 1'b0;
            for (int i = 0; i < KNL_MAXNUM; i++) begin
                r_bias[i] <= '0;
            end
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_addr_in <= ADDR_WIDTH'(PARAM_BASE);
                        r_idx     <= '0;
                        r_err     <= 1'b0;
                    end
                end
                S_LD_PARAM: begin
                    if (dram_valid) begin
                        case (r_idx)
                            2'd0: r_W <= data_in[DIM_WIDTH-1:0];
                            2'd1: r_H <= data_in[DIM_WIDTH-1:0];
                            2'd2: r_D <= data_in[DIM_WIDTH-1:0];
                            default: begin
                                r_mode  <= data_in[1:0];
`ifdef BIAS_ACT_LEAKY_EN
                                r_shift <= data_in[7:4];
`endif
                            end
                        endcase
                        r_idx     <= r_idx + 2'd1;
                        r_addr_in <= r_addr_in + c_ADDR_ONE;
                    end
                end
                S_CHECK: begin
                    r_err     <= w_dim_bad;
                    r_addr_in <= ADDR_WIDTH'(BIAS_BASE);
                    r_c       <= '0;
                end
                S_LD_BIAS: begin
                    if (dram_valid) begin
                        r_bias[IDXW'(r_c)] <= data_in;
                        r_c <= r_c + c_DIM_ONE;
                        if (w_c_last) begin
                            r_addr_in <= ADDR_WIDTH'(FMAP_BASE);
                            r_ptr     <= '0;
                            r_w       <= '0;
                            r_h       <= '0;
                            r_d       <= '0;
                        end else begin
                            r_addr_in <= r_addr_in + c_ADDR_ONE;
                        end
                    end
                end
                S_EVAL: begin
                    if (dram_valid) begin
                        r_wr       <= 1'b1;
                        r_data_out <= w_act;
                        r_addr_out <= ADDR_WIDTH'(OUT_BASE) + r_ptr;
                        r_ptr      <= r_ptr + c_ADDR_ONE;
                        r_addr_in  <= r_addr_in + c_ADDR_ONE;
                        // w fastest, then h, then d; d never wraps
                        if (w_w_last) begin
                            r_w <= '0;
                            if (w_h_last) begin
                                r_h <= '0;
                                if (!w_d_last) r_d <= r_d + c_DIM_ONE;
                            end else begin
                                r_h <= r_h + c_DIM_ONE;
                            end
                        end else begin
                            r_w <= r_w + c_DIM_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign addr_in    = r_addr_in;
    assign addr_out   = r_addr_out;
    assign data_out   = r_data_out;
    assign dram_en_wr = r_wr;

endmodule
`default_nettype wire

// File: tb/tb_bias_act_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bias_act_unit
//  Purpose  : Self-checking bench for bias_act_unit with a behavioural DRAM
//             (parameter / bias / feature-map regions) and a reference model
//             of the saturating bias add and activation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bias_act_unit;

    localparam int DW   = 32;
    localparam int AW   = 18;
    localparam int KN   = 64;
    localparam int DIMW = 7;   // wide enough to express D = 65
    localparam int PB   = 0;
    localparam int BB   = 61440;
    localparam int FB   = 131072;
    localparam int OB   = 131072;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          dram_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [AW-1:0] addr_in;
    logic          dram_en_rd;
    logic [AW-1:0] addr_out;
    logic [DW-1:0] data_out;
    logic          dram_en_wr;
    logic          busy;
    logic          done;
    logic          err;

    bias_act_unit #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .KNL_MAXNUM (KN),
        .DIM_WIDTH  (DIMW),
        .PARAM_BASE (PB),
        .BIAS_BASE  (BB),
        .FMAP_BASE  (FB),
        .OUT_BASE   (OB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .dram_valid (dram_valid),
        .data_in    (data_in),
        .addr_in    (addr_in),
        .dram_en_rd (dram_en_rd),
        .addr_out   (addr_out),
        .data_out   (data_out),
        .dram_en_wr (dram_en_wr),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural DRAM contents ----------------
    logic [31:0] pmem [4];
    logic [31:0] bmem [128];
    logic [31:0] fmem [4096];

    int gate_mode = 0;   // 0: always ready, 1: every other cycle, 2: random
    bit tog = 1'b0;
    bit go;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] wr_addr [$];
    logic [DW-1:0] wr_data [$];
    int done_cnt, err_cnt, err_alone, bias_rd_cnt;
    int cyc = 0, last_wr_cyc = 0, done_cyc = 0;

    function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
        int ia;
        ia = int'(a);
        if (ia >= PB && ia < PB + 4)     return pmem[ia - PB];
        if (ia >= BB && ia < BB + 128)   return bmem[ia - BB];
        if (ia >= FB && ia < FB + 4096)  return fmem[ia - FB];
        return 32'hDEADBEEF;
    endfunction

    // Monitor and DRAM responder, both away from the active edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (dram_en_wr) begin
            wr_addr.push_back(addr_out);
            wr_data.push_back(data_out);
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (err) begin
            err_cnt = err_cnt + 1;
            if (!done) err_alone = err_alone + 1;
        end
        tog = ~tog;
        go  = (gate_mode == 0) || (gate_mode == 1 && tog) ||
              (gate_mode == 2 && ($urandom_range(0, 1) == 1));
        dram_valid = dram_en_rd && go;
        data_in    = dram_en_rd ? mem_rd(addr_in) : 32'h0;
        if (dram_valid && int'(addr_in) >= BB && int'(addr_in) < BB + 128)
            bias_rd_cnt = bias_rd_cnt + 1;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_act(input logic [31:0] px, input logic [31:0] b,
                                            input int mode, input int sh);
        longint s;
        s = longint'($signed(px)) + longint'($signed(b));
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        if (mode == 2) return s[31:0];
`ifdef BIAS_ACT_LEAKY_EN
        if (mode == 1) return (s < 0) ? 32'(s >>> sh) : s[31:0];
`endif
        return (s < 0) ? 32'h0 : s[31:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic set_params(input int w, input int h, input int d, input logic [31:0] mw);
        pmem[0] = 32'(w);
        pmem[1] = 32'(h);
        pmem[2] = 32'(d);
        pmem[3] = mw;
    endtask

    // Starts a run and waits (bounded) for done; checks exactly one done pulse
    task automatic do_run(input int gm, input string nm);
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0; err_cnt = 0; err_alone = 0; bias_rd_cnt = 0;
        gate_mode = gm;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 5000 && done_cnt == 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk({nm, " done pulses"}, 64'(done_cnt), 64'd1);
    endtask

    task automatic check_run(input string nm, input int w, input int h, input int d,
                             input logic [31:0] mw);
        int n, base_fail, ch;
        logic [31:0] e;
        n = w * h * d;
        chk({nm, " write count"}, 64'(wr_addr.size()), 64'(n));
        chk({nm, " err pulses"}, 64'(err_cnt), 64'd0);
        base_fail = n_fail;
        for (int p = 0; p < n && p < wr_addr.size(); p++) begin
            ch = p / (w * h);
            e  = ref_act(fmem[p], bmem[ch], int'(mw[1:0]), int'(mw[7:4]));
            chk($sformatf("%s addr[%0d]", nm, p), 64'(wr_addr[p]), 64'(OB + p));
            chk($sformatf("%s data[%0d]", nm, p), 64'(wr_data[p]), 64'(e));
            if (n_fail != base_fail) break;
        end
    endtask

    // ---------------- fixed 2x2x2 scenario ----------------
    logic [31:0] px_fix  [8];
    logic [31:0] exp_fix [8];

    task automatic load_fixed();
        set_params(2, 2, 2, 32'h0);
        bmem[0] = 32'd5;
        bmem[1] = -32'sd5;
        for (int i = 0; i < 8; i++) fmem[i] = px_fix[i];
    endtask

    task automatic check_fixed(input string nm);
        chk({nm, " write count"}, 64'(wr_addr.size()), 64'd8);
        for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
            chk($sformatf("%s addr[%0d]", nm, i), 64'(wr_addr[i]), 64'(OB + i));
            chk($sformatf("%s data[%0d]", nm, i), 64'(wr_data[i]), 64'(exp_fix[i]));
        end
        chk({nm, " done after flush"}, 64'(done_cyc), 64'(last_wr_cyc + 1));
    endtask

    // ---------------- single-pixel vector table ----------------
    typedef struct {
        logic [31:0] mw;
        logic [31:0] b;
        logic [31:0] px;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [11];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w, h, d, n0;
        logic [31:0] mw;

        px_fix  = '{-32'sd10, 32'd3, -32'sd1, 32'd7, 32'd20, 32'd2, 32'd4, 32'd6};
        exp_fix = '{32'd0, 32'd8, 32'd4, 32'd12, 32'd15, 32'd0, 32'd0, 32'd1};
        for (int i = 0; i < 128; i++)  bmem[i] = '0;
        for (int i = 0; i < 4096; i++) fmem[i] = '0;

        tbl[0]  = '{32'h00, 32'h0,        32'h5,        32'h5};
        tbl[1]  = '{32'h00, 32'h0,        32'hFFFFFFF9, 32'h0};
        tbl[2]  = '{32'h02, 32'h20,       32'h7FFFFFF0, 32'h7FFFFFFF};
        tbl[3]  = '{32'h02, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
        tbl[4]  = '{32'h03, 32'h3,        32'hFFFFFFF6, 32'h0};
`ifdef BIAS_ACT_LEAKY_EN
        tbl[5]  = '{32'h21, 32'h0,        32'hFFFFFFF0, 32'hFFFFFFFC};
        tbl[9]  = '{32'h31, 32'h0,        32'h80000000, 32'hF0000000};
`else
        tbl[5]  = '{32'h21, 32'h0,        32'hFFFFFFF0, 32'h0};
        tbl[9]  = '{32'h31, 32'h0,        32'h80000000, 32'h0};
`endif
        tbl[6]  = '{32'hF2, 32'hFFFFFF9C, 32'h32,       32'hFFFFFFCE};
        tbl[7]  = '{32'h00, 32'h7FFFFFFF, 32'h1,        32'h7FFFFFFF};
        tbl[8]  = '{32'h01, 32'h1,        32'h9,        32'hA};
        tbl[10] = '{32'h13, 32'h0,        32'h10,       32'h10};

        // asynchronous reset: outputs must clear before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("reset addrs", 64'({addr_in, addr_out}), 64'd0);
        chk("reset data/flags", 64'({data_out, dram_en_rd, dram_en_wr, busy, done, err}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // table of single-pixel runs
        for (int i = 0; i < 11; i++) begin
            set_params(1, 1, 1, tbl[i].mw);
            bmem[0] = tbl[i].b;
            fmem[0] = tbl[i].px;
            do_run(i % 3, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d count", i), 64'(wr_addr.size()), 64'd1);
            if (wr_addr.size() > 0) begin
                chk($sformatf("vec%0d addr", i), 64'(wr_addr[0]), 64'(OB));
                chk($sformatf("vec%0d data", i), 64'(wr_data[0]), 64'(tbl[i].exp));
            end
        end

        // fixed scenario, no stalls then stalls every other cycle
        load_fixed();
        do_run(0, "fixed");
        check_fixed("fixed");
        do_run(1, "fixed_stall");
        check_fixed("fixed_stall");

        // depth above register-file size: abort without bias reads or writes
        set_params(1, 1, 65, 32'h0);
        do_run(0, "d65");
        chk("d65 writes", 64'(wr_addr.size()), 64'd0);
        chk("d65 bias reads", 64'(bias_rd_cnt), 64'd0);
        chk("d65 err pulses", 64'(err_cnt), 64'd1);
        chk("d65 err without done", 64'(err_alone), 64'd0);

        // zero width also aborts
        set_params(0, 2, 2, 32'h0);
        do_run(2, "w0");
        chk("w0 writes", 64'(wr_addr.size()), 64'd0);
        chk("w0 err pulses", 64'(err_cnt), 64'd1);

        // full-depth boundary D = KNL_MAXNUM
        set_params(1, 1, 64, 32'h2);
        for (int i = 0; i < 64; i++) begin
            bmem[i] = $urandom;
            fmem[i] = $urandom;
        end
        do_run(2, "d64");
        check_run("d64", 1, 1, 64, 32'h2);

        // randomized runs against the reference model
        for (int r = 0; r < 6; r++) begin
            w  = $urandom_range(1, 5);
            h  = $urandom_range(1, 4);
            d  = $urandom_range(1, 6);
            mw = $urandom;
            set_params(w, h, d, mw);
            for (int i = 0; i < d; i++)
                bmem[i] = ($urandom_range(0, 1) == 1) ? $urandom : (32'($urandom_range(0, 200)) - 32'd100);
            for (int i = 0; i < w * h * d; i++)
                fmem[i] = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 200)) - 32'd100);
            do_run(r % 3, $sformatf("rand%0d", r));
            check_run($sformatf("rand%0d", r), w, h, d, mw);
        end

        // reset mid-run after three writes
        load_fixed();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0; err_cnt = 0; err_alone = 0; bias_rd_cnt = 0;
        gate_mode = 0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            #1;
            if (wr_addr.size() >= 3) break;
        end
        chk("midrst reached 3 writes", 64'(wr_addr.size()), 64'd3);
        rst = 1'b1;
        #1;
        chk("midrst addrs", 64'({addr_in, addr_out}), 64'd0);
        chk("midrst data/flags", 64'({data_out, dram_en_rd, dram_en_wr, busy, done, err}), 64'd0);
        n0 = wr_addr.size();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst no further writes", 64'(wr_addr.size()), 64'(n0));
        chk("midrst no done", 64'(done_cnt), 64'd0);

        do_run(2, "after_rst");
        check_fixed("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bias_act_unit.md
BIAS_ACT_UNIT -- requirements
Module: bias_act_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: signed two's-complement word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 18: DRAM address width.
REQ-003 SHALL have parameter KNL_MAXNUM, default 64: bias register-file depth, which is the maximum channel count.
REQ-004 SHALL have parameter DIM_WIDTH, default 6: width of the width, height and depth counters.
REQ-005 SHALL have parameters PARAM_BASE 0, BIAS_BASE 61440, FMAP_BASE 131072 and OUT_BASE 131072 (in-place by default).
REQ-006 SHALL use one clock; reset is asynchronous and active-high.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 enable  input  1  start request; sampled in IDLE only.
REQ-010 dram_valid  input  1  data_in holds valid read data this cycle.
REQ-011 data_in  input  DATA_WIDTH  DRAM read data.
REQ-012 addr_in  output  ADDR_WIDTH  read address.
REQ-013 dram_en_rd  output  1  read request.
REQ-014 addr_out  output  ADDR_WIDTH  write address.
REQ-015 data_out  output  DATA_WIDTH  write data.
REQ-016 dram_en_wr  output  1  write strobe, one cycle per pixel.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 err  output  1  one-cycle pulse coincident with done when the run is aborted.

Function
REQ-020 SHALL implement the states IDLE, LD_PARAM, CHECK, LD_BIAS, EVAL, FLUSH and DONE.
REQ-021 SHALL transition IDLE to LD_PARAM when enable=1, and SHALL ignore enable in all other states.
REQ-022 SHALL hold addr_in with dram_en_rd=1 in LD_PARAM, LD_BIAS and EVAL until dram_valid=1, then advance the address on the next cycle; exactly one read is outstanding at any time.
REQ-023 LD_PARAM SHALL read 4 words at PARAM_BASE+0..3: W, H, D (each taken from bits [DIM_WIDTH-1:0]), then the mode word (mode=[1:0], shift=[7:4]).
REQ-024 CHECK SHALL last one cycle and SHALL go to DONE with err=1 if W=0, H=0, D=0 or D>KNL_MAXNUM; otherwise it SHALL go to LD_BIAS.
REQ-025 LD_BIAS SHALL load D words from BIAS_BASE+c into bias[c], c=0..D-1; entries at or above D keep their old values.
REQ-026 EVAL SHALL read pixels at FMAP_BASE+p and write them at OUT_BASE+p, where p=(d*H+h)*W+w is produced by an incrementing pointer, not a multiplier, with the order w fastest, then h, then d.
REQ-027 For each pixel, s SHALL be data_in+bias[d] saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-028 mode 0 (ReLU) SHALL output 0 if s<0, else s.
REQ-029 mode 1 (leaky) SHALL output s>>>shift if s<0, else s.
REQ-030 mode 2 (bias only) SHALL output s.
REQ-031 mode 3 SHALL behave as mode 0.
REQ-032 Latency: a pixel's dram_valid at cycle t SHALL give dram_en_wr=1 at t+1, with addr_out and data_out both registered.
REQ-033 After the last pixel's dram_valid, the block SHALL enter FLUSH for one cycle (the final write), then DONE.
REQ-034 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-035 A W×H×D run SHALL produce exactly W*H*D writes, with no duplicate or skipped address.
REQ-036 Counter wrap SHALL be: w reaching W-1 clears w and increments h; w=W-1 and h=H-1 together clear h and increment d; no counter wraps past D-1.
REQ-037 Stalls (dram_valid=0) SHALL hold every counter, address and mode register, and SHALL produce no writes.

Reset
REQ-038 rst=1 SHALL immediately force state IDLE and clear all counters, bias entries, W, H, D, mode, shift, addr_in, addr_out, data_out, dram_en_rd, dram_en_wr, busy, done and err to 0, independent of clk.
REQ-039 A reset mid-run SHALL abandon the run with no further writes; the next enable SHALL start a full run from LD_PARAM.

Configuration
REQ-040 The macro BIAS_ACT_LEAKY_EN SHALL control leaky mode.
REQ-041 With BIAS_ACT_LEAKY_EN defined, mode 1 SHALL behave per REQ-029, and shift SHALL be the 4-bit value from the mode word.
REQ-042 Without BIAS_ACT_LEAKY_EN, mode 1 SHALL behave as mode 0, the shift logic SHALL be absent, and shift bits SHALL be ignored.

Verification
REQ-043 W=2, H=2, D=2, mode 0, bias {5,-5}, pixels {-10,3,-1,7,20,2,4,6} with dram_valid always 1 -> writes {0,8,4,12,15,0,0,1} at OUT_BASE+0..7, then done one cycle after the FLUSH write.
REQ-044 The same run with dram_valid low on every other cycle -> identical write sequence, with one write per dram_valid pulse.
REQ-045 mode 1, shift=2, BIAS_ACT_LEAKY_EN defined, bias 0, pixel -16 -> -4; with the macro undefined -> 0.
REQ-046 Data 0x7FFFFFF0 with bias 0x20, mode 2 -> 0x7FFFFFFF; data 0x80000000 with bias -1 -> 0x80000000.
REQ-047 D=65 with KNL_MAXNUM=64 -> no bias reads, no writes, and done=err=1 in the same cycle.
REQ-048 rst asserted during EVAL after 3 writes -> all outputs 0 within the same cycle, no writes after; a fresh enable completes a correct full run.
